// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read-side ping-pong buffer.
// Holds the buffer state encoding and the default geometry constants.
package sdram_pkg;

    localparam int PP_ADDR_WIDTH = 9;
    localparam int PP_DATA_WIDTH = 32;
    localparam int PP_DEPTH      = 2 ** PP_ADDR_WIDTH;
    localparam int PP_CNT_WIDTH  = PP_ADDR_WIDTH + 1;
    localparam int PP_SIZE_WIDTH = 24;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_WRITING = 2'd1,
        BUF_FULL    = 2'd2,
        BUF_READING = 2'd3
    } buf_state_t;

    // A buffer "holds" data for the reader once committed and until released.
    function automatic logic buf_held(input buf_state_t s);
        return (s == BUF_FULL) || (s == BUF_READING);
    endfunction

endpackage

// File: rtl/sdram_read_ppfifo_if.sv
// Handshake bundle between the SDRAM read engine, the ping-pong buffer and
// the Wishbone-side consumer. master = engine/consumer side, slave = buffer.
interface sdram_read_ppfifo_if #(
    parameter int DATA_WIDTH = sdram_pkg::PP_DATA_WIDTH
);
    logic                                fifo_reset;
    logic [1:0]                          fifo_ready;
    logic [1:0]                          fifo_activate;
    logic [sdram_pkg::PP_SIZE_WIDTH-1:0] fifo_size;
    logic                                fifo_write;
    logic [DATA_WIDTH-1:0]               fifo_data;
    logic                                starved;
    logic                                wr_overflow;
    logic                                rd_ready;
    logic                                rd_activate;
    logic [sdram_pkg::PP_SIZE_WIDTH-1:0] rd_size;
    logic                                rd_strobe;
    logic [DATA_WIDTH-1:0]               rd_data;

    modport master (
        output fifo_reset, fifo_activate, fifo_write, fifo_data, rd_activate, rd_strobe,
        input  fifo_ready, fifo_size, starved, wr_overflow, rd_ready, rd_size, rd_data
    );

    modport slave (
        input  fifo_reset, fifo_activate, fifo_write, fifo_data, rd_activate, rd_strobe,
        output fifo_ready, fifo_size, starved, wr_overflow, rd_ready, rd_size, rd_data
    );

endinterface

// File: rtl/sdram_ppfifo_bank.sv
// Simple dual-port RAM with a registered, enable-gated read port.
// The read register holds its value whenever re is low.
module sdram_ppfifo_bank #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sdram_read_ppfifo.sv
// Two-buffer ping-pong between the SDRAM read engine and the Wishbone reader.
// Buffers are committed and handed to the reader strictly in fill order.
//
// state       | meaning
// ------------+--------------------------------------------------
// BUF_EMPTY   | free, advertised on fifo_ready
// BUF_WRITING | claimed by the engine, accepting fifo_write words
// BUF_FULL    | committed, waiting for the reader
// BUF_READING | owned by the reader until rd_activate falls
module sdram_read_ppfifo
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH = PP_ADDR_WIDTH,
    parameter int DATA_WIDTH = PP_DATA_WIDTH
) (
    input logic                clk,
    input logic                rst,
    sdram_read_ppfifo_if.slave bus
);

    localparam int               CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_WIDTH);

    buf_state_t         state    [2];
    logic [CNT_W-1:0]   wr_count [2];
    logic [CNT_W-1:0]   cnt_nxt  [2];
    logic [1:0]         act_prev, act_rise, act_fall;
    logic [1:0]         claim, commit, abandon, held_nxt;
    logic               rd_act_prev, rd_next;
    logic               any_reading, reading, rd_ready_c;
    logic               rd_start, rd_release, rd_step, rd_en;
    logic               wr_sel, wr_any, wr_accept, wr_drop;
    logic [CNT_W-1:0]   rd_ptr, rd_size_q, rd_addr;
    logic               wr_overflow_q, starved_q;
    logic [ADDR_WIDTH:0] ram_waddr, ram_raddr;

    always_comb begin
        act_rise    = bus.fifo_activate & ~act_prev;
        act_fall    = ~bus.fifo_activate & act_prev;
        // Simultaneous rises: buffer 0 wins, buffer 1's rise is discarded.
        claim[0]    = act_rise[0] && (state[0] == BUF_EMPTY);
        claim[1]    = act_rise[1] && !act_rise[0] && (state[1] == BUF_EMPTY);

        wr_sel      = (state[0] != BUF_WRITING);
        wr_any      = (state[0] == BUF_WRITING) || (state[1] == BUF_WRITING);
        wr_accept   = bus.fifo_write && wr_any && (wr_count[wr_sel] < DEPTH);
        wr_drop     = bus.fifo_write && !wr_accept;

        any_reading = (state[0] == BUF_READING) || (state[1] == BUF_READING);
        reading     = (state[rd_next] == BUF_READING);
        rd_ready_c  = (state[rd_next] == BUF_FULL) && !any_reading;
        rd_start    = bus.rd_activate && !rd_act_prev && rd_ready_c;
        rd_release  = !bus.rd_activate && rd_act_prev && reading;
        rd_step     = bus.rd_strobe && reading && (rd_ptr < rd_size_q);
        // Look one word ahead on a strobe; stop fetching past the end so
        // rd_data keeps the last word.
        rd_addr     = rd_ptr + CNT_W'(rd_step);
        rd_en       = reading && (rd_addr < rd_size_q);

        for (int i = 0; i < 2; i++) begin
            cnt_nxt[i]  = wr_count[i] + CNT_W'(wr_accept && (wr_sel == 1'(i)));
            commit[i]   = act_fall[i] && (state[i] == BUF_WRITING) && (cnt_nxt[i] != '0);
            abandon[i]  = act_fall[i] && (state[i] == BUF_WRITING) && (cnt_nxt[i] == '0);
            held_nxt[i] = commit[i] ||
                          (buf_held(state[i]) && !(rd_release && (rd_next == 1'(i))));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state[0]      <= BUF_EMPTY;
            state[1]      <= BUF_EMPTY;
            wr_count[0]   <= '0;
            wr_count[1]   <= '0;
            act_prev      <= '0;
            rd_act_prev   <= 1'b0;
            rd_next       <= 1'b0;
            rd_ptr        <= '0;
            rd_size_q     <= '0;
            wr_overflow_q <= 1'b0;
            starved_q     <= 1'b1;
        end else begin
            act_prev    <= bus.fifo_activate;
            rd_act_prev <= bus.rd_activate;
            starved_q   <= !(buf_held(state[0]) || buf_held(state[1]));
            if (bus.fifo_reset) begin
                state[0]      <= BUF_EMPTY;
                state[1]      <= BUF_EMPTY;
                wr_count[0]   <= '0;
                wr_count[1]   <= '0;
                rd_next       <= 1'b0;
                rd_ptr        <= '0;
                rd_size_q     <= '0;
                wr_overflow_q <= 1'b0;
            end else begin
                wr_overflow_q <= wr_drop;
                for (int i = 0; i < 2; i++) begin
                    if (claim[i]) begin
                        state[i]    <= BUF_WRITING;
                        wr_count[i] <= '0;
                    end else begin
                        wr_count[i] <= cnt_nxt[i];
                        if (commit[i]) begin
                            state[i] <= BUF_FULL;
                        end else if (abandon[i]) begin
                            state[i] <= BUF_EMPTY;
                        end else if (rd_start && (rd_next == 1'(i))) begin
                            state[i] <= BUF_READING;
                        end else if (rd_release && (rd_next == 1'(i))) begin
                            state[i] <= BUF_EMPTY;
                        end
                    end
                end
                // rd_next only moves off a buffer once it no longer holds data,
                // which keeps it on the oldest committed buffer.
                if (!held_nxt[rd_next] && held_nxt[~rd_next]) begin
                    rd_next <= ~rd_next;
                end
                if (rd_start) begin
                    rd_size_q <= wr_count[rd_next];
                    rd_ptr    <= '0;
                end else if (rd_step) begin
                    rd_ptr <= rd_ptr + CNT_W'(1);
                end
            end
        end
    end

    assign ram_waddr = {wr_sel, wr_count[wr_sel][ADDR_WIDTH-1:0]};
    assign ram_raddr = {rd_next, rd_addr[ADDR_WIDTH-1:0]};

    sdram_ppfifo_bank #(
        .ADDR_WIDTH (ADDR_WIDTH + 1),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept && !bus.fifo_reset),
        .waddr (ram_waddr),
        .wdata (bus.fifo_data),
        .re    (rd_en),
        .raddr (ram_raddr),
        .rdata (bus.rd_data)
    );

    assign bus.fifo_ready  = {state[1] == BUF_EMPTY, state[0] == BUF_EMPTY};
    assign bus.fifo_size   = PP_SIZE_WIDTH'(DEPTH);
    assign bus.starved     = starved_q;
    assign bus.wr_overflow = wr_overflow_q;
    assign bus.rd_ready    = rd_ready_c;
    assign bus.rd_size     = PP_SIZE_WIDTH'(rd_size_q);

endmodule
